// File: rtl/aligner_pkg.sv
// aligner_pkg: shared widths, flag bit positions and FSM states for the aligner controller
package aligner_pkg;
  localparam int DATA_IN_WIDTH  = 272;
  localparam int LEN_WIDTH      = 8;
  localparam int DATA_OUT_WIDTH = 256;
  localparam int KEEP_WIDTH     = DATA_OUT_WIDTH / 8;
  localparam int MAX_LEN        = DATA_IN_WIDTH / 8;
  localparam int FLG_LAST  = 2;
  localparam int FLG_COMP  = 1;
  localparam int FLG_HDR   = 0;
  localparam int AFL_VALID = 2;
  localparam int AFL_STALL = 1;
  localparam int AFL_LAST  = 0;
  localparam logic [3:0] BUBBLE_FLAGS = 4'b1010;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;
endpackage

// File: rtl/aligner_if.sv
// aligner_if: upstream beat stream, aligner side-band and downstream word stream
interface aligner_if;
  import aligner_pkg::*;
  logic                      s_valid;
  logic                      s_ready;
  logic [DATA_IN_WIDTH-1:0]  s_data;
  logic [LEN_WIDTH-1:0]      s_len;
  logic [2:0]                s_flags;
  logic                      al_wrt_en;
  logic [DATA_IN_WIDTH-1:0]  al_data;
  logic [LEN_WIDTH-1:0]      al_len;
  logic [3:0]                al_flags;
  logic [DATA_OUT_WIDTH-1:0] al_data_out;
  logic [2:0]                al_flags_out;
  logic [KEEP_WIDTH-1:0]     al_tkeep;
  logic                      m_valid;
  logic                      m_ready;
  logic [DATA_OUT_WIDTH-1:0] m_data;
  logic [KEEP_WIDTH-1:0]     m_keep;
  logic                      m_last;
  modport master (
    input  s_valid, s_data, s_len, s_flags, al_data_out, al_flags_out, al_tkeep, m_ready,
    output s_ready, al_wrt_en, al_data, al_len, al_flags, m_valid, m_data, m_keep, m_last
  );
  modport slave (
    output s_valid, s_data, s_len, s_flags, al_data_out, al_flags_out, al_tkeep, m_ready,
    input  s_ready, al_wrt_en, al_data, al_len, al_flags, m_valid, m_data, m_keep, m_last
  );
endinterface

// File: rtl/aligner_out_stage.sv
// aligner_out_stage: registered valid/ready word stage with handshake counter
module aligner_out_stage
  import aligner_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      adv_i,
  input  logic                      wvalid_i,
  input  logic [DATA_OUT_WIDTH-1:0] data_i,
  input  logic [KEEP_WIDTH-1:0]     keep_i,
  input  logic                      last_i,
  input  logic                      m_ready_i,
  output logic                      m_valid_o,
  output logic [DATA_OUT_WIDTH-1:0] m_data_o,
  output logic [KEEP_WIDTH-1:0]     m_keep_o,
  output logic                      m_last_o,
  output logic [31:0]               word_cnt_o
);
  logic                      m_valid_q, m_last_q, load;
  logic [DATA_OUT_WIDTH-1:0] m_data_q;
  logic [KEEP_WIDTH-1:0]     m_keep_q;
  logic [31:0]               word_cnt_q;
  assign load = adv_i & wvalid_i;
  // load a new aligner word on advance; otherwise hold until the consumer takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      m_valid_q <= load | (m_valid_q & ~m_ready_i);
      if (load) begin
        m_data_q <= data_i;
        m_keep_q <= keep_i;
        m_last_q <= last_i;
      end
      if (m_valid_q & m_ready_i) word_cnt_q <= word_cnt_q + 32'd1;
    end
  end
  assign m_valid_o  = m_valid_q;
  assign m_data_o   = m_data_q;
  assign m_keep_o   = m_keep_q;
  assign m_last_o   = m_last_q;
  assign word_cnt_o = word_cnt_q;
endmodule

// File: rtl/aligner_ctrl.sv
// aligner_ctrl: holds compressor beats at the aligner, inserts drain bubbles and re-times its output
module aligner_ctrl
  import aligner_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  aligner_if.master   bus,
  output logic        len_err,
  output logic [31:0] word_cnt
);
  state_t                   state_q, state_d;
  logic [DATA_IN_WIDTH-1:0] hr_data_q;
  logic [LEN_WIDTH-1:0]     hr_len_q;
  logic [2:0]               hr_flags_q;
  logic                     pend_last_q, len_err_q;
  logic                     adv, drain, drain_stay, accept;
  assign adv        = (state_q != IDLE) & (~bus.m_valid | bus.m_ready);
  assign drain      = bus.al_flags_out[AFL_STALL] |
                      (hr_flags_q[FLG_LAST] & ~bus.al_flags_out[AFL_LAST] &
                       hr_flags_q[FLG_COMP] & ~hr_flags_q[FLG_HDR]);
  assign drain_stay = bus.al_flags_out[AFL_STALL] | (pend_last_q & ~bus.al_flags_out[AFL_LAST]);
  assign bus.s_ready = (state_q == IDLE) | ((state_q == FEED) & adv & ~drain);
  assign accept     = bus.s_valid & bus.s_ready;
  // next state: wait for a beat, feed it, and keep bubbling while the aligner still owes a word
  always_comb begin
    state_d = (state_q == IDLE) ? (accept ? FEED : IDLE)
            : ~adv              ? state_q
            : (state_q == FEED) ? (drain ? DRAIN : (accept ? FEED : IDLE))
            : (drain_stay ? DRAIN : IDLE);
  end
  // state, hold register, pending-last for the drain, and sticky length error
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hr_data_q   <= '0;
      hr_len_q    <= '0;
      hr_flags_q  <= '0;
      pend_last_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hr_data_q  <= bus.s_data;
        hr_len_q   <= bus.s_len;
        hr_flags_q <= bus.s_flags;
      end
      if ((state_q == FEED) & adv & drain) pend_last_q <= hr_flags_q[FLG_LAST];
      if (accept & bus.s_flags[FLG_COMP] & ~bus.s_flags[FLG_HDR] & (bus.s_len > LEN_WIDTH'(MAX_LEN)))
        len_err_q <= 1'b1;
    end
  end
  assign bus.al_wrt_en = adv;
  assign bus.al_data   = (state_q == FEED) ? hr_data_q : '0;
  assign bus.al_len    = (state_q == FEED) ? hr_len_q : '0;
  assign bus.al_flags  = (state_q == FEED) ? {1'b1, hr_flags_q} : (state_q == DRAIN) ? BUBBLE_FLAGS : 4'b0;
  assign len_err       = len_err_q;
  aligner_out_stage u_out (
    .clk        (clk),
    .reset      (reset),
    .adv_i      (adv),
    .wvalid_i   (bus.al_flags_out[AFL_VALID]),
    .data_i     (bus.al_data_out),
    .keep_i     (bus.al_tkeep),
    .last_i     (bus.al_flags_out[AFL_LAST]),
    .m_ready_i  (bus.m_ready),
    .m_valid_o  (bus.m_valid),
    .m_data_o   (bus.m_data),
    .m_keep_o   (bus.m_keep),
    .m_last_o   (bus.m_last),
    .word_cnt_o (word_cnt)
  );
endmodule

// File: tb/tb_aligner_ctrl.sv
// tb_aligner_ctrl: directed bench with a byte-packing aligner model and a word scoreboard
module tb_aligner_ctrl;
  import aligner_pkg::*;
  typedef struct packed {logic [255:0] d; logic [31:0] k; logic l;} word_t;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         len_err;
  logic [31:0]  word_cnt;
  int           n_cmp = 0, n_err = 0, cyc = 0, n_push = 0, acc_cyc = 0, first_acc, h0;
  int           hs_cyc[$];
  word_t        sb[$];
  word_t        mw;
  logic [767:0] rf_buf = '0;
  int           rf_cnt = 0;
  logic [271:0] last_d, a_d, b_d;
  logic [767:0] rb_q, cmb, pay;
  int           cnt_q, tot;
  logic         pl_q, lf, a_full, a_valid, a_last;

  aligner_if bus();
  aligner_ctrl dut (.clk(clk), .reset(reset), .bus(bus), .len_err(len_err), .word_cnt(word_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // aligner stand-in: packs bytes, emits one 32-byte word per write, flags stall when a second full word is pending
  always_comb begin
    pay     = 768'(bus.al_data) & ((768'(1) << (32'(bus.al_len) * 8)) - 768'(1));
    cmb     = rb_q | (pay << (cnt_q * 8));
    tot     = cnt_q + 32'(bus.al_len);
    lf      = pl_q | (bus.al_flags[3] & bus.al_flags[2]);
    a_full  = tot >= 32;
    a_valid = a_full | (lf && tot > 0);
    a_last  = a_valid & lf & (tot <= 32);
    bus.al_flags_out = {a_valid, tot >= 64, a_last};
    bus.al_data_out  = cmb[255:0];
    bus.al_tkeep     = a_full ? 32'hFFFF_FFFF : 32'((33'(1) << tot) - 33'(1));
  end
  always @(posedge clk) begin
    if (reset) begin
      rb_q <= '0; cnt_q <= 0; pl_q <= 1'b0;
    end else if (bus.al_wrt_en) begin
      rb_q  <= a_valid ? (a_last ? '0 : cmb >> 256) : cmb;
      cnt_q <= a_valid ? (a_last ? 0 : tot - 32) : tot;
      pl_q  <= lf & ~a_last;
    end
  end

  // scoreboard consumer
  always @(negedge clk) begin
    if (!reset && bus.m_valid && bus.m_ready) begin
      hs_cyc.push_back(cyc);
      chk("word_expected", 256'(sb.size() != 0), 256'(1));
      if (sb.size() != 0) begin
        mw = sb.pop_front();
        chk("m_data", bus.m_data, mw.d);
        chk("m_keep", 256'(bus.m_keep), 256'(mw.k));
        chk("m_last", 256'(bus.m_last), 256'(mw.l));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int len, input logic last);
    logic r;
    int k, c;
    last_d = '0;
    for (int i = 0; i < 8; i++) last_d[i*32 +: 32] = $urandom;
    last_d[271:256] = 16'($urandom);
    rf_buf = rf_buf | ((768'(last_d) & ((768'(1) << (len * 8)) - 768'(1))) << (rf_cnt * 8));
    rf_cnt += len;
    while (rf_cnt >= 32) begin
      sb.push_back({rf_buf[255:0], 32'hFFFF_FFFF, last && rf_cnt == 32});
      n_push++;
      rf_buf = rf_buf >> 256;
      rf_cnt -= 32;
    end
    if (last && rf_cnt > 0) begin
      sb.push_back({rf_buf[255:0], 32'((33'(1) << rf_cnt) - 33'(1)), 1'b1});
      n_push++;
      rf_buf = '0;
      rf_cnt = 0;
    end
    bus.s_valid = 1'b1; bus.s_data = last_d; bus.s_len = 8'(len); bus.s_flags = {last, 2'b10};
    r = 1'b0; k = 0; c = 0;
    while (!r && k < 50) begin
      @(negedge clk); r = bus.s_ready; c = cyc;
      @(posedge clk); #1; k++;
    end
    chk("accept", 256'(r), 256'(1));
    acc_cyc = c;
    bus.s_valid = 1'b0;
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_len = '0; bus.s_flags = '0; bus.m_ready = 1'b1;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", 256'(bus.s_ready), 256'(1));
    chk("rst_m_valid", 256'(bus.m_valid), 256'(0));
    chk("rst_word_cnt", 256'(word_cnt), 256'(0));
    chk("rst_wrt_en", 256'(bus.al_wrt_en), 256'(0));
    chk("rst_len_err", 256'(len_err), 256'(0));
    @(posedge clk); #1;
    // eight aligned compressed beats streaming at full rate
    h0 = hs_cyc.size();
    send(32, 1'b0);
    first_acc = acc_cyc;
    for (int i = 1; i < 8; i++) send(32, i == 7);
    idle(4);
    chk("burst_words", 256'(hs_cyc.size() - h0), 256'(8));
    chk("burst_latency", 256'(hs_cyc[h0] - first_acc), 256'(2));
    chk("burst_span", 256'(hs_cyc[h0+7] - hs_cyc[h0]), 256'(7));
    // residual 30 bytes plus a full 34-byte beat forces a stall bubble
    h0 = hs_cyc.size();
    send(30, 1'b0);
    send(34, 1'b0);
    @(negedge clk);
    chk("feed_len", 256'(bus.al_len), 256'(34));
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_drain_s_ready", 256'(bus.s_ready), 256'(0));
    chk("stall_bubble_len", 256'(bus.al_len), 256'(0));
    chk("stall_bubble_data", 256'(bus.al_data), 256'(0));
    chk("stall_bubble_wrt", 256'(bus.al_wrt_en), 256'(1));
    @(posedge clk); #1;
    idle(3);
    chk("stall_words", 256'(hs_cyc.size() - h0), 256'(2));
    chk("stall_b2b", 256'(hs_cyc[h0+1] - hs_cyc[h0]), 256'(1));
    // last beat overflowing the word by one byte
    send(30, 1'b0);
    send(3, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("eop_drain_s_ready", 256'(bus.s_ready), 256'(0));
    chk("eop_drain_flags", 256'(bus.al_flags), 256'(4'b1010));
    @(posedge clk); #1;
    @(negedge clk);
    chk("eop_keep", 256'(bus.m_keep), 256'(32'h1));
    chk("eop_last", 256'(bus.m_last), 256'(1));
    chk("eop_idle_flags", 256'(bus.al_flags), 256'(0));
    chk("eop_idle_s_ready", 256'(bus.s_ready), 256'(1));
    @(posedge clk); #1;
    idle(2);
    // downstream backpressure for five cycles mid-stream
    send(32, 1'b0); a_d = last_d;
    send(32, 1'b0); b_d = last_d;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_wrt_en", 256'(bus.al_wrt_en), 256'(0));
      chk("bp_al_data", 256'(bus.al_data), 256'(b_d));
      chk("bp_al_len", 256'(bus.al_len), 256'(32));
      chk("bp_m_valid", 256'(bus.m_valid), 256'(1));
      chk("bp_m_data", bus.m_data, a_d[255:0]);
      chk("bp_s_ready", 256'(bus.s_ready), 256'(0));
      @(posedge clk); #1;
    end
    bus.m_ready = 1'b1;
    send(32, 1'b1);
    idle(4);
    // oversize compressed beat sets the sticky length error
    chk("len_err_clear", 256'(len_err), 256'(0));
    send(40, 1'b1);
    @(negedge clk);
    chk("len_err_set", 256'(len_err), 256'(1));
    @(posedge clk); #1;
    idle(5);
    chk("len_err_sticky", 256'(len_err), 256'(1));
    chk("sb_drained", 256'(sb.size()), 256'(0));
    chk("word_cnt", 256'(word_cnt), 256'(n_push));
    // reset while a drain is pending
    send(30, 1'b0);
    send(34, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("pre_rst_drain", 256'(bus.s_ready), 256'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    rf_buf = '0; rf_cnt = 0; n_push = 0;
    @(negedge clk);
    chk("mid_rst_s_ready", 256'(bus.s_ready), 256'(1));
    chk("mid_rst_m_valid", 256'(bus.m_valid), 256'(0));
    chk("mid_rst_wrt_en", 256'(bus.al_wrt_en), 256'(0));
    chk("mid_rst_word_cnt", 256'(word_cnt), 256'(0));
    chk("mid_rst_len_err", 256'(len_err), 256'(0));
    @(posedge clk); #1;
    send(32, 1'b1);
    idle(4);
    chk("post_rst_word_cnt", 256'(word_cnt), 256'(n_push));
    chk("post_rst_sb", 256'(sb.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aligner_ctrl.md
# aligner_ctrl

Sequencing controller for the 256-bit output aligner in the compression write path. It accepts tagged compressor beats over a valid/ready stream, holds each beat stable at the aligner inputs, and pulses the aligner write enable only when downstream can take a word. It inserts zero-length drain bubbles on aligner stall or end-of-packet overflow, and re-times aligner output into a registered valid/ready master stream with keep and last.

## Interface
- DATA_IN_WIDTH, 272, tagged input beat width.
- TAG_WIDTH, 16, tag bits at the beat LSBs, stripped on bypass beats.
- LEN_WIDTH, 8, byte-length field width.
- DATA_OUT_WIDTH, 256, aligned word width.
- MAX_LEN, 34, largest legal byte length, equal to DATA_IN_WIDTH/8.

Clock and reset are fixed: one clock, synchronous active-high reset.

- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  beat accepted when s_valid & s_ready.
- s_data  in  DATA_IN_WIDTH  beat payload.
- s_len  in  LEN_WIDTH  payload byte count.
- s_flags  in  3  {last, compressed, header}.
- al_wrt_en  out  1  aligner register write enable.
- al_data  out  DATA_IN_WIDTH  held payload, or 0 during a bubble.
- al_len  out  LEN_WIDTH  held length, or 0 during a bubble.
- al_flags  out  4  {valid_align, last, compressed, header}.
- al_data_out  in  DATA_OUT_WIDTH  aligner word.
- al_flags_out  in  3  {valid, stall, last_out}.
- al_tkeep  in  DATA_OUT_WIDTH/8  aligner keep.
- m_valid  out  1  word valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_OUT_WIDTH  word.
- m_keep  out  DATA_OUT_WIDTH/8  byte keep.
- m_last  out  1  final word of packet.
- len_err  out  1  sticky flag; set when an accepted beat has compressed=1, header=0 and s_len > MAX_LEN.
- word_cnt  out  32  number of m_valid & m_ready handshakes; wraps.

## Operation
- Hold register (HR): stores data, len and flags of the accepted beat. A beat is accepted on s_valid & s_ready.
- States:
  - IDLE: HR empty.
  - FEED: HR is presented on al_* with valid_align=1.
  - DRAIN: bubble presented, with al_data=0, al_len=0 and al_flags={1,0,1,0}.
- adv = (state!=IDLE) & (~m_valid | m_ready). al_wrt_en = adv.
- On adv, if al_flags_out.valid=1, the output register loads:
  - m_data ← al_data_out;
  - m_keep ← al_tkeep;
  - m_last ← al_flags_out.last_out.
- If adv and no word is loaded, m_valid ← 0 when m_ready; otherwise m_valid is held.
- Drain needed = al_flags_out.stall, or (HR.last & ~al_flags_out.last_out & HR.compressed & ~HR.header).
- Transitions:
  - IDLE → FEED on accept.
  - FEED, adv, drain needed → DRAIN. HR.last is copied to pend_last.
  - FEED, adv, no drain → FEED if a new beat is accepted the same cycle, else IDLE.
  - DRAIN, adv → stay DRAIN while al_flags_out.stall=1 or (pend_last & ~al_flags_out.last_out); otherwise IDLE.
- s_ready = (state==IDLE) | (state==FEED & adv & ~drain needed). There is no acceptance during DRAIN.
- Bypass beats (compressed=0 or header=1) are fed like any other beat. The aligner emits them directly, so they never need a drain.
- len_err does not block traffic. It is cleared only by reset.

## Timing
- Reset values: state=IDLE, HR=0, pend_last=0, m_valid=0, m_data=0, m_keep=0, m_last=0, len_err=0, word_cnt=0, s_ready=1, al_wrt_en=0.
- Latency: a beat accepted in cycle N drives al_* in N+1. The word is visible on m_* in N+2 when not backpressured.
- Throughput: one beat per cycle with m_ready=1 and no drains. Each drain bubble costs one cycle.
- al_* are stable from the cycle after acceptance until the adv cycle.
- m_* are stable while m_valid & ~m_ready.
- Simultaneous m_ready and a new aligner word: the output register is replaced in the same cycle, with no bubble.
- Reset mid-packet returns the controller to IDLE. A pending drain is discarded. The aligner shares reset and clears with it.

## Structure
- Package aligner_pkg:
  - state enum {IDLE, FEED, DRAIN};
  - index constants for the flag bits (FLG_LAST, FLG_COMP, FLG_HDR, AFL_VALID, AFL_STALL, AFL_LAST);
  - MAX_LEN.
- The output register with valid/ready is natural as one sub-module, out_stage.
- The aligner itself is instantiated by the parent, not inside this block.

## Test plan
- Reset, then idle: s_ready=1, m_valid=0, word_cnt=0, al_wrt_en=0.
- Eight compressed beats of 32 bytes each, with m_ready=1, using an aligner model: eight words, one per cycle starting 2 cycles after the first acceptance; keep=32'hFFFFFFFF; m_last only on the eighth word.
- Residual 240 bits plus a 34-byte beat (stall): one DRAIN cycle is inserted and s_ready=0 during it. Two words are emitted back to back, and no data is lost against the reference model.
- Last beat that overflows by 8 bits: DRAIN emits a final word with m_keep=32'h00000001 and m_last=1, then the controller returns to IDLE.
- m_ready held 0 for 5 cycles mid-stream: al_wrt_en=0, and al_* and m_* stay constant throughout. Streaming resumes with no duplicate or lost word.
- Compressed beat with s_len=40: len_err goes to 1 and stays 1. Reset during DRAIN: the next cycle shows state IDLE and m_valid=0.
